pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_gen_if.sv | 26 ++
 rtl/pulse_train_gen.sv | 113 +++++++++++
 tb/tb_pulse_train_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pulse_train_gen_if.sv
// Control and status bundle for the pulse train generator.
// The controller drives the burst request; the generator drives the pulse train and status.
interface pulse_train_gen_if #(
    parameter int CNT_W  = 8,
    parameter int TIME_W = 16
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  num_pulses;
    logic [TIME_W-1:0] high_cycles;
    logic [TIME_W-1:0] low_cycles;
    logic              pulse_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pulses_sent;

    modport master (
        output start, abort, num_pulses, high_cycles, low_cycles,
        input  pulse_out, busy, done, pulses_sent
    );

    modport slave (
        input  start, abort, num_pulses, high_cycles, low_cycles,
        output pulse_out, busy, done, pulses_sent
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Burst pulse train generator: emits N pulses of H high / L low cycles on request.
// All outputs are registered copies of the decoded next state.
module pulse_train_gen #(
    parameter int CNT_W  = 8,
    parameter int TIME_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pulse_train_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    localparam logic [TIME_W-1:0] ONE_T = TIME_W'(1);

    state_t            state_reg, state_next;
    logic [TIME_W-1:0] cnt_reg, cnt_next;
    logic [TIME_W-1:0] h_reg, h_next;
    logic [TIME_W-1:0] l_reg, l_next;
    logic [CNT_W-1:0]  n_reg, n_next;
    logic [CNT_W-1:0]  sent_reg, sent_next;
    logic [CNT_W-1:0]  sent_inc;
    logic              pulse_out_reg, pulse_out_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    assign sent_inc = sent_reg + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= ONE_T;
            h_reg         <= ONE_T;
            l_reg         <= ONE_T;
            n_reg         <= '0;
            sent_reg      <= '0;
            pulse_out_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            h_reg         <= h_next;
            l_reg         <= l_next;
            n_reg         <= n_next;
            sent_reg      <= sent_next;
            pulse_out_reg <= pulse_out_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // Phase counter runs 1..latched duration; zero durations are clamped to 1 at latch time.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        h_next     = h_reg;
        l_next     = l_reg;
        n_next     = n_reg;
        sent_next  = sent_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    n_next     = bus.num_pulses;
                    h_next     = (bus.high_cycles == '0) ? ONE_T : bus.high_cycles;
                    l_next     = (bus.low_cycles == '0) ? ONE_T : bus.low_cycles;
                    sent_next  = '0;
                    cnt_next   = ONE_T;
                    state_next = (bus.num_pulses == '0) ? DONE : HIGH;
                end
            end
            HIGH: begin
                if (cnt_reg == h_reg) begin
                    sent_next  = sent_inc;
                    cnt_next   = ONE_T;
                    state_next = (sent_inc == n_reg) ? DONE : LOW;
                end else begin
                    cnt_next = cnt_reg + ONE_T;
                end
            end
            LOW: begin
                if (cnt_reg == l_reg) begin
                    cnt_next   = ONE_T;
                    state_next = HIGH;
                end else begin
                    cnt_next = cnt_reg + ONE_T;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // An abort freezes the completed-pulse count, even on the last high cycle.
        if (bus.abort && (state_reg != IDLE)) begin
            state_next = IDLE;
            sent_next  = sent_reg;
            cnt_next   = ONE_T;
        end
    end

    always_comb begin
        pulse_out_next = (state_next == HIGH);
        busy_next      = (state_next != IDLE);
        done_next      = (state_next == DONE);
    end

    assign bus.pulse_out   = pulse_out_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.pulses_sent = sent_reg;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed checks of pulse_train_gen bursts, abort, reset and held start,
// with a downstream click counter on pulse_out.
module tb_pulse_train_gen;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   clicks = 0;
    logic prev_pulse = 1'b0;

    pulse_train_gen_if #(.CNT_W(8), .TIME_W(16)) bus ();

    pulse_train_gen #(.CNT_W(8), .TIME_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Downstream click input: counts rising edges of pulse_out.
    always @(posedge clk) begin
        prev_pulse <= bus.pulse_out;
        if (bus.pulse_out && !prev_pulse)
            clicks <= clicks + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample outputs, then advance one cycle, n times.
    task automatic watch(input int n, output logic [31:0] pat, output int busy_n, output int done_n);
        pat = '0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < n; i++) begin
            pat = {pat[30:0], bus.pulse_out};
            busy_n += int'(bus.busy);
            done_n += int'(bus.done);
            tick();
        end
    endtask

    task automatic launch(input logic [7:0] n, input logic [15:0] h, input logic [15:0] l);
        bus.num_pulses  = n;
        bus.high_cycles = h;
        bus.low_cycles  = l;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    logic [31:0] pat;
    int busy_n, done_n, clicks0;

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_pulses = '0;
        bus.high_cycles = '0;
        bus.low_cycles = '0;
        reset = 1'b1;
        tick(); tick(); tick();
        check("rst_pulse", 32'(bus.pulse_out), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_done",  32'(bus.done), 0);
        check("rst_sent",  32'(bus.pulses_sent), 0);
        reset = 1'b0;
        tick();

        // N=3 H=2 L=3
        clicks0 = clicks;
        launch(8'd3, 16'd2, 16'd3);
        watch(14, pat, busy_n, done_n);
        check("b1_pattern", pat, 32'b11000110001100);
        check("b1_busy",    32'(busy_n), 13);
        check("b1_done",    32'(done_n), 1);
        check("b1_sent",    32'(bus.pulses_sent), 3);
        check("b1_clicks",  32'(clicks - clicks0), 3);

        // N=0
        launch(8'd0, 16'd5, 16'd5);
        check("z_busy", 32'(bus.busy), 1);
        check("z_done", 32'(bus.done), 1);
        watch(3, pat, busy_n, done_n);
        check("z_pattern", pat, 0);
        check("z_busy_n",  32'(busy_n), 1);
        check("z_sent",    32'(bus.pulses_sent), 0);

        // N=2 H=0 L=0 clamps to 1
        launch(8'd2, 16'd0, 16'd0);
        watch(5, pat, busy_n, done_n);
        check("c_pattern", pat, 32'b10100);
        check("c_busy",    32'(busy_n), 4);
        check("c_done",    32'(done_n), 1);
        check("c_sent",    32'(bus.pulses_sent), 2);

        // N=5 H=4 L=4, abort in 3rd LOW phase
        launch(8'd5, 16'd4, 16'd4);
        watch(22, pat, busy_n, done_n);
        check("a_pattern", pat, 32'b1111000011110000111100);
        check("a_busy_pre", 32'(busy_n), 22);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("a_pulse", 32'(bus.pulse_out), 0);
        check("a_busy",  32'(bus.busy), 0);
        check("a_sent",  32'(bus.pulses_sent), 3);
        watch(10, pat, busy_n, done_n);
        check("a_done_n", 32'(done_n), 0);
        check("a_idle_busy", 32'(busy_n), 0);
        // abort alone in IDLE changes nothing
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("ai_sent", 32'(bus.pulses_sent), 3);
        check("ai_busy", 32'(bus.busy), 0);

        // N=4 H=3 L=2, reset in 2nd HIGH, then full burst
        launch(8'd4, 16'd3, 16'd2);
        watch(6, pat, busy_n, done_n);
        check("r_pulse_pre", 32'(bus.pulse_out), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_pulse", 32'(bus.pulse_out), 0);
        check("r_busy",  32'(bus.busy), 0);
        check("r_done",  32'(bus.done), 0);
        check("r_sent",  32'(bus.pulses_sent), 0);
        clicks0 = clicks;
        launch(8'd4, 16'd3, 16'd2);
        watch(20, pat, busy_n, done_n);
        check("r2_pattern", pat, 32'b11100111001110011100);
        check("r2_busy",    32'(busy_n), 19);
        check("r2_done",    32'(done_n), 1);
        check("r2_sent",    32'(bus.pulses_sent), 4);
        check("r2_clicks",  32'(clicks - clicks0), 4);

        // N=2 H=1 L=1 with start held and inputs changed mid-burst
        clicks0 = clicks;
        bus.num_pulses = 8'd2;
        bus.high_cycles = 16'd1;
        bus.low_cycles = 16'd1;
        bus.start = 1'b1;
        tick();
        bus.num_pulses = 8'd7;
        bus.high_cycles = 16'd5;
        watch(4, pat, busy_n, done_n);
        check("h_pattern", pat, 32'b1010);
        check("h_done",    32'(done_n), 1);
        check("h_idle_busy", 32'(bus.busy), 0);
        check("h_sent",    32'(bus.pulses_sent), 2);
        check("h_clicks",  32'(clicks - clicks0), 32'(bus.pulses_sent));
        tick();
        check("h2_pulse", 32'(bus.pulse_out), 1);
        check("h2_sent",  32'(bus.pulses_sent), 0);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("h2_abort_busy", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
